// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed, checksummed byte frame,
// writes the payload into instruction memory and holds the CPU until the load is good.
module imem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic [7:0] count
);

  typedef enum logic [2:0] {
    StLen,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] count_q, count_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       accept;

  assign in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      StLen: begin
        if (accept) begin
          len_d   = in_data;
          sum_d   = 8'h00;
          count_d = 8'h00;
          state_d = (in_data != 8'h00) ? StData : StChk;
        end
      end
      StData: begin
        if (accept) begin
          sum_d     = sum_q + in_data;
          count_d   = count_q + 8'd1;
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + count_q;
          wr_data_d = in_data;
          if (count_q + 8'd1 == len_q) state_d = StChk;
        end
      end
      StChk: begin
        if (accept) state_d = (in_data == sum_q) ? StDone : StErr;
      end
      StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          count_d = 8'h00;
        end
      end
      default: state_d = StLen;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StLen;
      len_q     <= 8'h00;
      sum_q     <= 8'h00;
      count_q   <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Status flags decode the registered state, so they change one cycle after the checksum byte.
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign done     = (state_q == StDone);
  assign error    = (state_q == StErr);
  assign cpu_hold = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader; a second instance with BASE_ADDR=FE checks wrap.
module tb_imem_loader;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready, wr_en, cpu_hold, done, error;
  logic [7:0] wr_addr, wr_data, count;
  logic       in_ready2, wr_en2, cpu_hold2, done2, error2;
  logic [7:0] wr_addr2, wr_data2, count2;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  imem_loader #(.BASE_ADDR(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .count(count)
  );

  imem_loader #(.BASE_ADDR(8'hFE)) dut_fe (
    .CLK(CLK), .RESET(RESET), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .cpu_hold(cpu_hold2), .done(done2), .error(error2), .count(count2)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       vld;
    logic [7:0] dat;
    logic       ready;
    logic       wen;
    logic [7:0] addr;
    logic [7:0] wdat;
    logic       dn;
    logic       err;
    logic       hold;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic st, input logic vld, input logic [7:0] dat,
                     input logic ready, input logic wen, input logic [7:0] addr,
                     input logic [7:0] wdat, input logic dn, input logic err,
                     input logic hold, input logic [7:0] cnt);
    vec_t v;
    v = '{rst, st, vld, dat, ready, wen, addr, wdat, dn, err, hold, cnt};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic st, input logic vld, input logic [7:0] dat);
    @(negedge CLK);
    RESET = rst; start = st; in_valid = vld; in_data = dat;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //  rst st vld dat    rdy wen addr   wdat   dn er hold cnt
    add(1, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 1, 8'd0);  // reset state
    add(0, 0, 1, 8'h03, 1, 0, 8'h00, 8'h00, 0, 0, 1, 8'd0);
    add(0, 0, 1, 8'h41, 1, 1, 8'h00, 8'h41, 0, 0, 1, 8'd1);
    add(0, 0, 1, 8'h82, 1, 1, 8'h01, 8'h82, 0, 0, 1, 8'd2);
    add(0, 0, 1, 8'hC3, 1, 1, 8'h02, 8'hC3, 0, 0, 1, 8'd3);
    add(0, 0, 1, 8'h86, 0, 0, 8'h02, 8'hC3, 1, 0, 0, 8'd3);
    add(0, 0, 0, 8'h00, 0, 0, 8'h02, 8'hC3, 1, 0, 0, 8'd3);
    add(0, 1, 0, 8'h00, 1, 0, 8'h02, 8'hC3, 0, 0, 1, 8'd0);  // reload
    add(0, 0, 1, 8'h02, 1, 0, 8'h02, 8'hC3, 0, 0, 1, 8'd0);  // bad checksum frame
    add(0, 0, 1, 8'h10, 1, 1, 8'h00, 8'h10, 0, 0, 1, 8'd1);
    add(0, 0, 1, 8'h20, 1, 1, 8'h01, 8'h20, 0, 0, 1, 8'd2);
    add(0, 0, 1, 8'h31, 0, 0, 8'h01, 8'h20, 0, 1, 1, 8'd2);
    add(0, 0, 1, 8'h55, 0, 0, 8'h01, 8'h20, 0, 1, 1, 8'd2);  // ignored while not ready
    add(0, 1, 0, 8'h00, 1, 0, 8'h01, 8'h20, 0, 0, 1, 8'd0);
    add(0, 0, 1, 8'h00, 1, 0, 8'h01, 8'h20, 0, 0, 1, 8'd0);  // empty frame, good
    add(0, 0, 1, 8'h00, 0, 0, 8'h01, 8'h20, 1, 0, 0, 8'd0);
    add(0, 1, 0, 8'h00, 1, 0, 8'h01, 8'h20, 0, 0, 1, 8'd0);
    add(0, 0, 1, 8'h00, 1, 0, 8'h01, 8'h20, 0, 0, 1, 8'd0);  // empty frame, bad
    add(0, 0, 1, 8'h05, 0, 0, 8'h01, 8'h20, 0, 1, 1, 8'd0);
    add(0, 1, 0, 8'h00, 1, 0, 8'h01, 8'h20, 0, 0, 1, 8'd0);
    add(0, 1, 0, 8'h00, 1, 0, 8'h01, 8'h20, 0, 0, 1, 8'd0);  // start ignored in LEN
    add(0, 0, 1, 8'h02, 1, 0, 8'h01, 8'h20, 0, 0, 1, 8'd0);  // toggling valid
    add(0, 1, 0, 8'h00, 1, 0, 8'h01, 8'h20, 0, 0, 1, 8'd0);  // start ignored in DATA
    add(0, 0, 1, 8'hAA, 1, 1, 8'h00, 8'hAA, 0, 0, 1, 8'd1);
    add(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'hAA, 0, 0, 1, 8'd1);
    add(0, 0, 1, 8'h55, 1, 1, 8'h01, 8'h55, 0, 0, 1, 8'd2);
    add(0, 0, 0, 8'h00, 1, 0, 8'h01, 8'h55, 0, 0, 1, 8'd2);
    add(0, 0, 1, 8'hFF, 0, 0, 8'h01, 8'h55, 1, 0, 0, 8'd2);
    add(0, 1, 0, 8'h00, 1, 0, 8'h01, 8'h55, 0, 0, 1, 8'd0);
    add(0, 0, 1, 8'h04, 1, 0, 8'h01, 8'h55, 0, 0, 1, 8'd0);  // abandoned frame
    add(0, 0, 1, 8'h11, 1, 1, 8'h00, 8'h11, 0, 0, 1, 8'd1);
    add(0, 0, 1, 8'h22, 1, 1, 8'h01, 8'h22, 0, 0, 1, 8'd2);
    add(1, 0, 1, 8'h33, 1, 0, 8'h00, 8'h00, 0, 0, 1, 8'd0);  // reset beats acceptance
    add(0, 0, 1, 8'h01, 1, 0, 8'h00, 8'h00, 0, 0, 1, 8'd0);
    add(0, 0, 1, 8'h7F, 1, 1, 8'h00, 8'h7F, 0, 0, 1, 8'd1);
    add(0, 0, 1, 8'h7F, 0, 0, 8'h00, 8'h7F, 1, 0, 0, 8'd1);
    add(1, 1, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 1, 8'd0);  // reset beats start

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].st, vq[i].vld, vq[i].dat);
      chk("in_ready", i, {7'd0, in_ready}, {7'd0, vq[i].ready});
      chk("wr_en",    i, {7'd0, wr_en},    {7'd0, vq[i].wen});
      chk("wr_addr",  i, wr_addr,          vq[i].addr);
      chk("wr_data",  i, wr_data,          vq[i].wdat);
      chk("done",     i, {7'd0, done},     {7'd0, vq[i].dn});
      chk("error",    i, {7'd0, error},    {7'd0, vq[i].err});
      chk("cpu_hold", i, {7'd0, cpu_hold}, {7'd0, vq[i].hold});
      chk("count",    i, count,            vq[i].cnt);
    end

    // Address wrap on the BASE_ADDR=FE instance.
    begin
      logic [7:0] wrap_addr [3];
      logic [7:0] payload [3];
      wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFF; wrap_addr[2] = 8'h00;
      payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03;
      step(1, 0, 0, 8'h00);
      chk("fe_reset_addr", 0, wr_addr2, 8'hFE);
      step(0, 0, 1, 8'h03);
      for (int i = 0; i < 3; i++) begin
        step(0, 0, 1, payload[i]);
        chk("fe_wr_en",   i, {7'd0, wr_en2}, 8'd1);
        chk("fe_wr_addr", i, wr_addr2, wrap_addr[i]);
        chk("fe_wr_data", i, wr_data2, payload[i]);
      end
      step(0, 0, 1, 8'h06);
      chk("fe_done", 0, {7'd0, done2}, 8'd1);
      chk("fe_hold", 0, {7'd0, cpu_hold2}, 8'd0);
      chk("fe_count", 0, count2, 8'd3);
    end

    // Maximum length frame: 255 bytes, count must stop at 255.
    begin
      logic [7:0] sum;
      int n_wr;
      sum = 8'h00;
      n_wr = 0;
      step(0, 1, 0, 8'h00);
      step(0, 0, 1, 8'hFF);
      for (int i = 0; i < 255; i++) begin
        step(0, 0, 1, 8'(i * 7 + 3));
        sum = sum + 8'(i * 7 + 3);
        if (wr_en === 1'b1 && wr_addr === 8'(i) && wr_data === 8'(i * 7 + 3)) n_wr++;
      end
      chk("max_writes", 0, 8'(n_wr), 8'd255);
      chk("max_count", 0, count, 8'hFF);
      chk("max_in_chk", 0, {7'd0, in_ready}, 8'd1);
      step(0, 0, 1, sum);
      chk("max_done", 0, {7'd0, done}, 8'd1);
      chk("max_count_end", 0, count, 8'hFF);
      chk("max_last_addr", 0, wr_addr, 8'hFE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'h00, the instruction memory address written by the first program byte.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: reload request, sampled only in DONE or ERR.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream byte valid.
REQ-006 The block SHALL have port in_data, input, 8 bits: upstream byte.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port wr_en, output, 1 bit: instruction memory write strobe.
REQ-009 The block SHALL have port wr_addr, output, 8 bits: instruction memory write address.
REQ-010 The block SHALL have port wr_data, output, 8 bits: instruction byte to write.
REQ-011 The block SHALL have port cpu_hold, output, 1 bit: holds the CPU in reset while high.
REQ-012 The block SHALL have port done, output, 1 bit: program loaded and checksum good.
REQ-013 The block SHALL have port error, output, 1 bit: checksum mismatch.
REQ-014 The block SHALL have port count, output, 8 bits: number of instruction bytes written so far.

Function
REQ-015 A byte SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_valid SHALL be ignored when in_ready is 0.
REQ-016 The frame format SHALL be: one length byte N (0-255), then N instruction bytes, then one checksum byte equal to the 8-bit modulo-256 sum of the N instruction bytes.
REQ-017 The FSM SHALL have states LEN, DATA, CHK, DONE and ERR, and in_ready SHALL be combinationally 1 in LEN, DATA and CHK and 0 in DONE and ERR.
REQ-018 On acceptance in LEN, the block SHALL latch N, clear the running sum and count, and go to DATA if N != 0 or to CHK if N == 0.
REQ-019 On each acceptance in DATA, the block SHALL add the byte to the sum and increment count.
REQ-020 On each acceptance in DATA, the block SHALL register wr_en=1, wr_addr=(BASE_ADDR+count before increment) mod 256 and wr_data=byte for exactly the next cycle (latency 1).
REQ-021 On the acceptance in DATA that makes count equal to N, the block SHALL go to CHK.
REQ-022 wr_en SHALL be 0 in every cycle not following a DATA acceptance.
REQ-023 wr_addr and wr_data SHALL hold their last values while wr_en is 0.
REQ-024 On acceptance in CHK, the block SHALL go to DONE if the byte equals the sum, otherwise to ERR.
REQ-025 done SHALL be 1 only in DONE and error SHALL be 1 only in ERR; both SHALL be registered, becoming 1 the cycle after the checksum byte is accepted.
REQ-026 cpu_hold SHALL be 1 in every state except DONE; DONE SHALL persist until start or RESET, and ERR SHALL persist until start or RESET.
REQ-027 In DONE or ERR, start=1 SHALL move the FSM to LEN on the next edge, clearing done, error and count and raising cpu_hold; start SHALL be ignored in LEN, DATA and CHK.
REQ-028 Address arithmetic SHALL wrap modulo 256: with BASE_ADDR=8'hFE and N=3, the writes go to FE, FF, 00.
REQ-029 count SHALL be reported in 8 bits; N=255 is the largest length, and count never exceeds N.
REQ-030 Upstream stalls (in_valid=0) in any state SHALL not change state, sum, count or outputs, except for the one-cycle wr_en pulse.

Reset
REQ-031 While RESET=1 at a rising edge, the FSM SHALL go to LEN and the outputs SHALL be wr_en=0, wr_addr=BASE_ADDR, wr_data=8'h00, cpu_hold=1, done=0, error=0, count=0, with the sum cleared.
REQ-032 RESET SHALL take priority over start and over a simultaneous byte acceptance.
REQ-033 RESET mid-frame SHALL abandon the frame with no further writes, and the next accepted byte SHALL be treated as a length byte.

Verification
REQ-034 Stream 03,41,82,C3,86 with BASE_ADDR=0 and in_valid held high -> writes (00,41),(01,82),(02,C3) each one cycle after acceptance; then done=1, cpu_hold=0, count=3.
REQ-035 Stream 02,10,20,31 -> two writes, then error=1, done=0, cpu_hold=1, in_ready=0; a start pulse -> LEN with error=0 and count=0.
REQ-036 Stream 00,00 -> no writes and done=1; stream 00,05 -> error=1.
REQ-037 BASE_ADDR=FE, stream 03,01,02,03,06 -> wr_addr sequence FE, FF, 00, then done=1.
REQ-038 Stream 04,11,22 then RESET for one cycle, then 01,7F,7F -> no write after reset until (00,7F), then done=1.
REQ-039 Stream 02,AA,55,FF with in_valid toggling every cycle -> writes identical to the continuous case, one write per accepted byte, then done=1.
